ws2812_frame_ctrl: RTL and testbench
====================================

// Module: ws2812_frame_ctrl
// PURPOSE
//  Sequences the 25-bit WS2812 shift-register datapath for one chain node.
//  - Detects the bus reset (line held low >= TRESET_CYCLES) and issues the treset pulse.
//  - Counts this node's 24 decoded bits, then commits the pixel to a valid/ready output.
//  - Switches the node to passthrough and counts forwarded bits until the next reset.
//  Sits between the bit decoder/shift register and the pixel consumer and output mux.
// PARAMETERS
//  TRESET_CYCLES  5000  line-low clocks that constitute a WS2812 reset (50 us @ 100 MHz)
//  CNT_W          16    width of forwarded-bit and frame counters
// PORTS
//  i_clk           in   1      system clock
//  i_reset         in   1      synchronous, active-high reset
//  i_line          in   1      synchronized serial line level
//  i_bit_valid     in   1      1-cycle strobe: decoded bit available
//  i_led_data      in   24     upper 24 bits of shift register (GRB)
//  o_treset        out  1      1-cycle pulse: reload shift register to reset value
//  o_passthru_en   out  1      1 while state==FORWARD; selects passthrough on output mux
//  o_pixel_data    out  24     committed GRB pixel
//  o_pixel_valid   out  1      pixel handshake valid
//  i_pixel_ready   in   1      pixel handshake ready
//  o_fwd_count     out  CNT_W  bits forwarded in current frame, saturating
//  o_frame_count   out  CNT_W  frames with a committed pixel, wrapping
//  o_err_short     out  1      1-cycle pulse: reset arrived mid-capture
//  o_overrun       out  1      sticky: pixel dropped because output still held
// BEHAVIOUR
//  - Reset values:
//    - All outputs are 0; counters are 0; state is WAIT_RST.
//  - Reset detector:
//    - low_cnt increments while i_line==0 and clears when i_line==1.
//    - o_treset pulses on the cycle low_cnt reaches TRESET_CYCLES-1.
//    - low_cnt then saturates; no repeat pulse until the line has gone high.
//  - Priority: o_treset beats i_bit_valid in the same cycle; that strobe is ignored.
//  - FSM (ctrl_state_t):
//    - WAIT_RST: ignore strobes; on treset -> IDLE. Prevents mid-stream misalignment.
//    - IDLE: on i_bit_valid -> CAPTURE, bit_cnt=1.
//    - CAPTURE: each strobe does bit_cnt++.
//      - 24th strobe -> COMMIT.
//      - treset -> IDLE, o_err_short pulse, bit_cnt=0, nothing emitted.
//    - COMMIT: exactly one cycle; sample i_led_data (shift reg updated on 24th strobe edge) -> FORWARD.
//    - FORWARD: o_passthru_en=1; each strobe does o_fwd_count++ (saturate at all-ones).
//      - On treset -> IDLE, o_fwd_count=0, o_frame_count++.
//  - Latency: o_pixel_valid rises 2 clocks after the 24th i_bit_valid edge.
//  - Handshake:
//    - valid and data are held stable until valid&&ready; then valid drops the next cycle.
//    - COMMIT with valid=0, or with valid&&ready, loads new data; valid is 1 the next cycle.
//    - COMMIT with valid&&!ready drops the new pixel, keeps old data, and sets o_overrun.
//  - o_overrun is cleared only by i_reset.
//  - o_frame_count wraps modulo 2^CNT_W.
//  - i_reset mid-frame: everything returns to WAIT_RST immediately; a pending pixel is discarded.
// STRUCTURE
//  - pipeline_types gains:
//    - ctrl_state_t enum {WAIT_RST, IDLE, CAPTURE, COMMIT, FORWARD}
//    - pixel_t (logic [23:0])
//    - C_BITS_PER_LED=24
//  - Sub-module treset_detector (params TRESET_CYCLES): i_clk, i_reset, i_line -> o_treset.
//  - FSM, counters and output register live in this module.
// TESTING (TRESET_CYCLES=8 in bench)
//  1. Reset, then 24 strobes with no prior line-low -> stays WAIT_RST, o_pixel_valid=0.
//  2. 8 low clocks, then 24 bits of 0xA5C33C with ready=1
//     -> o_treset single pulse; o_pixel_data=0xA5C33C, valid 2 clks after 24th strobe;
//        o_passthru_en=1.
//  3. After case 2, send 48 more strobes then 8 low clocks
//     -> o_fwd_count=48, then 0; o_frame_count=1; state IDLE.
//  4. 10 strobes then a line-low reset -> o_err_short one pulse, no valid, next frame captures cleanly.
//  5. ready=0, two frames 0x111111 then 0x222222
//     -> data stays 0x111111, o_overrun=1; then ready=1 -> handshake completes, valid drops.
//  6. Line low coincident with a strobe on cycle TRESET_CYCLES-1 -> strobe ignored, treset wins;
//     assert i_reset mid-CAPTURE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ws2812_frame_ctrl_pkg.sv
// rtl/ws2812_frame_ctrl_pkg.sv - shared types and constants for the WS2812 frame controller
// Purpose: control FSM state encoding, pixel type and per-LED bit count.
// Ports: none (package).
package ws2812_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_RST = 3'd0,
        IDLE     = 3'd1,
        CAPTURE  = 3'd2,
        COMMIT   = 3'd3,
        FORWARD  = 3'd4
    } ctrl_state_t;

    typedef logic [23:0] pixel_t;

    localparam int C_BITS_PER_LED = 24;

endpackage

// File: rtl/ws2812_frame_ctrl_treset_detector.sv
// rtl/ws2812_frame_ctrl_treset_detector.sv - WS2812 bus reset (long line-low) detector
// Purpose: counts consecutive low clocks on the serial line and emits a single
//          treset pulse once the low period reaches TRESET_CYCLES.
// Ports:
//   i_clk     in  1  system clock
//   i_reset   in  1  synchronous, active-high reset
//   i_line    in  1  synchronized serial line level
//   o_treset  out 1  1-cycle pulse, visible on the TRESET_CYCLES-th low clock
module ws2812_frame_ctrl_treset_detector #(
    parameter int TRESET_CYCLES = 5000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_treset
);

    localparam int LOW_W = $clog2(TRESET_CYCLES);
    localparam logic [LOW_W-1:0] C_SAT = LOW_W'(TRESET_CYCLES - 1);
    localparam logic [LOW_W-1:0] C_PRE = LOW_W'(TRESET_CYCLES - 2);

    logic [LOW_W-1:0] r_low_cnt;
    logic             r_treset;

    // The counter parks at C_SAT while the line stays low, so the pulse fires
    // only on the C_PRE -> C_SAT transition and cannot repeat until the line
    // has gone high and cleared the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_low_cnt <= '0;
            r_treset  <= 1'b0;
        end else begin
            r_treset <= 1'b0;
            if (i_line) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != C_SAT) begin
                r_low_cnt <= r_low_cnt + 1'b1;
                r_treset  <= (r_low_cnt == C_PRE);
            end
        end
    end

    assign o_treset = r_treset;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - frame sequencer for one WS2812 chain node
// Purpose: detects bus reset, captures this node's 24 bits, commits the pixel
//          to a valid/ready output, then forwards and counts remaining bits.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_line, i_bit_valid            serial line level, decoded-bit strobe
//   i_led_data[23:0]               upper 24 bits of the shift register (GRB)
//   o_treset                       shift-register reload pulse
//   o_passthru_en                  output mux select while forwarding
//   o_pixel_data/valid, i_pixel_ready  pixel handshake
//   o_fwd_count, o_frame_count     forwarded bits (saturating), frames (wrapping)
//   o_err_short, o_overrun         short-frame pulse, sticky pixel-drop flag
module ws2812_frame_ctrl
    import ws2812_frame_ctrl_pkg::*;
#(
    parameter int TRESET_CYCLES = 5000,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_line,
    input  logic             i_bit_valid,
    input  logic [23:0]      i_led_data,
    output logic             o_treset,
    output logic             o_passthru_en,
    output logic [23:0]      o_pixel_data,
    output logic             o_pixel_valid,
    input  logic             i_pixel_ready,
    output logic [CNT_W-1:0] o_fwd_count,
    output logic [CNT_W-1:0] o_frame_count,
    output logic             o_err_short,
    output logic             o_overrun
);

    localparam logic [4:0] C_LAST_BIT = 5'(C_BITS_PER_LED - 1);

    logic             w_treset;
    ctrl_state_t      r_state;
    logic [4:0]       r_bit_cnt;
    pixel_t           r_pixel_data;
    logic             r_pixel_valid;
    logic [CNT_W-1:0] r_fwd_count;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_err_short;
    logic             r_overrun;

    ws2812_frame_ctrl_treset_detector #(
        .TRESET_CYCLES(TRESET_CYCLES)
    ) u_treset_detector (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_line  (i_line),
        .o_treset(w_treset)
    );

    // In every state a treset is tested before i_bit_valid, so a strobe that
    // coincides with the reset pulse is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= WAIT_RST;
            r_bit_cnt     <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_fwd_count   <= '0;
            r_frame_count <= '0;
            r_err_short   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_err_short <= 1'b0;
            if (r_pixel_valid && i_pixel_ready) begin
                r_pixel_valid <= 1'b0;
            end

            case (r_state)
                // Never lock on mid-stream: wait for a clean frame boundary.
                WAIT_RST: begin
                    if (w_treset) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!w_treset && i_bit_valid) begin
                        r_state   <= CAPTURE;
                        r_bit_cnt <= 5'd1;
                    end
                end
                CAPTURE: begin
                    if (w_treset) begin
                        r_state     <= IDLE;
                        r_err_short <= 1'b1;
                        r_bit_cnt   <= '0;
                    end else if (i_bit_valid) begin
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_state   <= COMMIT;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                // The shift register took the 24th bit on the previous edge,
                // so i_led_data is complete here.
                COMMIT: begin
                    if (!r_pixel_valid || i_pixel_ready) begin
                        r_pixel_data  <= i_led_data;
                        r_pixel_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    if (w_treset) begin
                        r_state       <= IDLE;
                        r_frame_count <= r_frame_count + CNT_W'(1);
                    end else begin
                        r_state <= FORWARD;
                        if (i_bit_valid) begin
                            r_fwd_count <= CNT_W'(1);
                        end
                    end
                end
                FORWARD: begin
                    if (w_treset) begin
                        r_state       <= IDLE;
                        r_fwd_count   <= '0;
                        r_frame_count <= r_frame_count + CNT_W'(1);
                    end else if (i_bit_valid && (r_fwd_count != '1)) begin
                        r_fwd_count <= r_fwd_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= WAIT_RST;
                end
            endcase
        end
    end

    assign o_treset      = w_treset;
    assign o_passthru_en = (r_state == FORWARD);
    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_valid = r_pixel_valid;
    assign o_fwd_count   = r_fwd_count;
    assign o_frame_count = r_frame_count;
    assign o_err_short   = r_err_short;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - directed self-checking bench for ws2812_frame_ctrl
module tb_ws2812_frame_ctrl;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_line = 1'b1;
    logic        i_bit_valid = 1'b0;
    logic [23:0] i_led_data = '0;
    logic        i_pixel_ready = 1'b1;
    logic        o_treset;
    logic        o_passthru_en;
    logic [23:0] o_pixel_data;
    logic        o_pixel_valid;
    logic [15:0] o_fwd_count;
    logic [15:0] o_frame_count;
    logic        o_err_short;
    logic        o_overrun;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tr_cnt = 0;
    int          err_cnt = 0;
    logic        v_mid;
    logic [23:0] led = '0;

    always #5 clk = ~clk;

    ws2812_frame_ctrl #(
        .TRESET_CYCLES(8),
        .CNT_W        (16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_line       (i_line),
        .i_bit_valid  (i_bit_valid),
        .i_led_data   (i_led_data),
        .o_treset     (o_treset),
        .o_passthru_en(o_passthru_en),
        .o_pixel_data (o_pixel_data),
        .o_pixel_valid(o_pixel_valid),
        .i_pixel_ready(i_pixel_ready),
        .o_fwd_count  (o_fwd_count),
        .o_frame_count(o_frame_count),
        .o_err_short  (o_err_short),
        .o_overrun    (o_overrun)
    );

    always begin
        @(posedge clk);
        #1;
        if (o_treset) tr_cnt++;
        if (o_err_short) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One decoded bit: strobe for a cycle, then a gap cycle.  The modelled
    // shift register takes the bit on the strobe edge.
    task automatic send_bit(input logic b);
        i_bit_valid = 1'b1;
        @(negedge clk);
        v_mid = o_pixel_valid;
        i_bit_valid = 1'b0;
        led = {led[22:0], b};
        i_led_data = led;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[23-i]);
    endtask

    task automatic line_low(input int n, input int inject_at);
        i_line = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) i_bit_valid = 1'b1;
            @(negedge clk);
            i_bit_valid = 1'b0;
        end
        i_line = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({o_treset, o_passthru_en, o_pixel_valid, o_err_short, o_overrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {o_treset, o_passthru_en, o_pixel_valid, o_err_short, o_overrun});
        end
        n_cmp++;
        if ({o_pixel_data, o_fwd_count, o_frame_count} !== 56'h0) begin
            n_bad++;
            $display("FAIL reset_regs: data %h fwd %0d frame %0d want 0", o_pixel_data, o_fwd_count, o_frame_count);
        end
        i_reset = 1'b0;
        @(negedge clk);
        send_word(24'hFFFFFF, 24);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_pixel_valid !== 1'b0 || o_passthru_en !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_rst_ignore: valid %b passthru %b want 0 0", o_pixel_valid, o_passthru_en);
        end
    endtask

    task automatic test_capture();
        int t0;
        t0 = tr_cnt;
        i_pixel_ready = 1'b1;
        line_low(8, -1);
        n_cmp++;
        if (tr_cnt - t0 !== 1) begin
            n_bad++;
            $display("FAIL treset_pulse: got %0d pulses want 1", tr_cnt - t0);
        end
        send_word(24'hA5C33C, 23);
        n_cmp++;
        if (o_pixel_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL early_valid: got %b want 0", o_pixel_valid);
        end
        send_bit(1'b0);
        n_cmp++;
        if (v_mid !== 1'b0 || o_pixel_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL valid_latency: 1clk %b 2clk %b want 0 1", v_mid, o_pixel_valid);
        end
        n_cmp++;
        if (o_pixel_data !== 24'hA5C33C) begin
            n_bad++;
            $display("FAIL pixel_data: got %h want a5c33c", o_pixel_data);
        end
        n_cmp++;
        if (o_passthru_en !== 1'b1) begin
            n_bad++;
            $display("FAIL passthru_en: got %b want 1", o_passthru_en);
        end
        @(negedge clk);
        n_cmp++;
        if (o_pixel_valid !== 1'b0 || o_pixel_data !== 24'hA5C33C) begin
            n_bad++;
            $display("FAIL handshake_drop: valid %b data %h want 0 a5c33c", o_pixel_valid, o_pixel_data);
        end
    endtask

    task automatic test_forward();
        int t0;
        send_word(24'h0, 24);
        send_word(24'h0, 24);
        n_cmp++;
        if (o_fwd_count !== 16'd48) begin
            n_bad++;
            $display("FAIL fwd_count: got %0d want 48", o_fwd_count);
        end
        t0 = tr_cnt;
        line_low(12, -1);
        n_cmp++;
        if (tr_cnt - t0 !== 1) begin
            n_bad++;
            $display("FAIL treset_saturate: got %0d pulses want 1", tr_cnt - t0);
        end
        n_cmp++;
        if (o_fwd_count !== 16'd0 || o_frame_count !== 16'd1 || o_passthru_en !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end: fwd %0d frame %0d passthru %b want 0 1 0",
                     o_fwd_count, o_frame_count, o_passthru_en);
        end
    endtask

    task automatic test_short_frame();
        int e0;
        e0 = err_cnt;
        send_word(24'hFFC000, 10);
        line_low(8, -1);
        @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_bad++;
            $display("FAIL err_short: got %0d pulses want 1", err_cnt - e0);
        end
        n_cmp++;
        if (o_pixel_valid !== 1'b0 || o_pixel_data !== 24'hA5C33C) begin
            n_bad++;
            $display("FAIL short_no_emit: valid %b data %h want 0 a5c33c", o_pixel_valid, o_pixel_data);
        end
        send_word(24'h3C5A96, 24);
        n_cmp++;
        if (o_pixel_valid !== 1'b1 || o_pixel_data !== 24'h3C5A96) begin
            n_bad++;
            $display("FAIL recapture: valid %b data %h want 1 3c5a96", o_pixel_valid, o_pixel_data);
        end
        line_low(8, -1);
        n_cmp++;
        if (o_frame_count !== 16'd2) begin
            n_bad++;
            $display("FAIL frame_count2: got %0d want 2", o_frame_count);
        end
    endtask

    task automatic test_back_to_back();
        i_pixel_ready = 1'b0;
        send_word(24'h111111, 24);
        line_low(8, -1);
        send_word(24'h222222, 24);
        line_low(8, -1);
        n_cmp++;
        if (o_pixel_valid !== 1'b1 || o_pixel_data !== 24'h111111) begin
            n_bad++;
            $display("FAIL hold_data: valid %b data %h want 1 111111", o_pixel_valid, o_pixel_data);
        end
        n_cmp++;
        if (o_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun: got %b want 1", o_overrun);
        end
        n_cmp++;
        if (o_frame_count !== 16'd4) begin
            n_bad++;
            $display("FAIL frame_count4: got %0d want 4", o_frame_count);
        end
        i_pixel_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_pixel_valid !== 1'b0 || o_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL late_ready: valid %b overrun %b want 0 1", o_pixel_valid, o_overrun);
        end
    endtask

    task automatic test_priority_and_reset();
        int t0;
        t0 = tr_cnt;
        line_low(8, 7);
        n_cmp++;
        if (tr_cnt - t0 !== 1) begin
            n_bad++;
            $display("FAIL coincident_treset: got %0d pulses want 1", tr_cnt - t0);
        end
        i_pixel_ready = 1'b0;
        send_word(24'h0F0F0F, 23);
        n_cmp++;
        if (o_pixel_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL strobe_ignored: valid %b after 23 bits want 0", o_pixel_valid);
        end
        send_bit(1'b1);
        n_cmp++;
        if (o_pixel_valid !== 1'b1 || o_pixel_data !== 24'h0F0F0F) begin
            n_bad++;
            $display("FAIL pri_capture: valid %b data %h want 1 0f0f0f", o_pixel_valid, o_pixel_data);
        end
        line_low(8, -1);
        send_word(24'hF80000, 5);
        n_cmp++;
        if (o_frame_count !== 16'd5) begin
            n_bad++;
            $display("FAIL frame_count5: got %0d want 5", o_frame_count);
        end
        i_reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_treset, o_passthru_en, o_pixel_valid, o_err_short, o_overrun} !== 5'b0 ||
            {o_pixel_data, o_fwd_count, o_frame_count} !== 56'h0) begin
            n_bad++;
            $display("FAIL midframe_reset: flags %b data %h fwd %0d frame %0d want all 0",
                     {o_treset, o_passthru_en, o_pixel_valid, o_err_short, o_overrun},
                     o_pixel_data, o_fwd_count, o_frame_count);
        end
        i_reset = 1'b0;
        i_pixel_ready = 1'b1;
        send_word(24'hABCDEF, 24);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_pixel_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_wait: valid %b want 0", o_pixel_valid);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_short_frame();
        test_back_to_back();
        test_priority_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
